// File: rtl/scr1_memif_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | scr1_memif_arb: two-port arbiter sharing one core memory interface, with   |
// | an in-order owner tag FIFO steering bridge responses back to requesters.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module scr1_memif_arb #(
  parameter int ORDER_DEPTH = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int FIXED_PRIO  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  output logic                  m0_req_ack,
  input  logic                  m0_cmd,
  input  logic [1:0]            m0_width,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  output logic [31:0]           m0_rdata,
  output logic [1:0]            m0_resp,
  input  logic                  m1_req,
  output logic                  m1_req_ack,
  input  logic                  m1_cmd,
  input  logic [1:0]            m1_width,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  output logic [31:0]           m1_rdata,
  output logic [1:0]            m1_resp,
  output logic                  s_req,
  input  logic                  s_req_ack,
  output logic                  s_cmd,
  output logic [1:0]            s_width,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [31:0]           s_wdata,
  input  logic [31:0]           s_rdata,
  input  logic [1:0]            s_resp,
  output logic                  idle,
  output logic                  err_unexp
);

  localparam int PTR_W = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ORDER_DEPTH-1:0] tags_q, tags_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   last_q, last_d;
  logic                   err_q, err_d;

  logic w_any_req;
  logic w_full;
  logic w_empty;
  logic w_gnt1;
  logic w_accept;
  logic w_resp_vld;
  logic w_pop;
  logic w_head;

  assign w_any_req  = m0_req | m1_req;
  assign w_full     = (count_q == CNT_W'(ORDER_DEPTH));
  assign w_empty    = (count_q == '0);
  assign w_resp_vld = (s_resp != 2'b00);
  assign w_pop      = w_resp_vld & ~w_empty;
  assign w_head     = tags_q[rd_ptr_q];

  // On contention round-robin favours the port that did not win last time
  always_comb begin
    w_gnt1 = m1_req;
    if (m0_req & m1_req) begin
      w_gnt1 = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
    end
  end

  assign s_req      = w_any_req & ~w_full;
  assign w_accept   = s_req & s_req_ack;
  assign m0_req_ack = m0_req & ~w_gnt1 & s_req_ack & ~w_full;
  assign m1_req_ack = w_gnt1 & s_req_ack & ~w_full;

  always_comb begin
    s_cmd   = 1'b0;
    s_width = 2'b00;
    s_addr  = '0;
    s_wdata = '0;
    if (w_any_req) begin
      if (w_gnt1) begin
        s_cmd   = m1_cmd;
        s_width = m1_width;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
      end else begin
        s_cmd   = m0_cmd;
        s_width = m0_width;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
      end
    end
  end

  always_comb begin
    m0_resp  = 2'b00;
    m0_rdata = '0;
    m1_resp  = 2'b00;
    m1_rdata = '0;
    if (w_pop) begin
      if (w_head) begin
        m1_resp  = s_resp;
        m1_rdata = s_rdata;
      end else begin
        m0_resp  = s_resp;
        m0_rdata = s_rdata;
      end
    end
  end

  always_comb begin
    tags_d   = tags_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    err_d    = err_q | (w_resp_vld & w_empty);
    if (w_accept) begin
      tags_d[wr_ptr_q] = w_gnt1;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      last_d           = w_gnt1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({w_accept, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      tags_q   <= tags_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  assign idle      = w_empty;
  assign err_unexp = err_q;

endmodule
`default_nettype wire

// File: tb/tb_scr1_memif_arb.sv
`default_nettype none
// Bench for scr1_memif_arb: a round-robin and a fixed-priority instance share
// one directed stimulus and are both checked against a queue-based model.
module tb_scr1_memif_arb;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_cmd, m1_req, m1_cmd, s_req_ack;
  logic [1:0]  m0_width, m1_width, s_resp;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata;

  logic [1:0]  ack0, ack1, sreq, scmd, idle, err;
  logic [1:0]  resp0 [2];
  logic [1:0]  resp1 [2];
  logic [1:0]  swidth [2];
  logic [31:0] rdata0 [2];
  logic [31:0] rdata1 [2];
  logic [31:0] saddr [2];
  logic [31:0] swdata [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: one owner entry per outstanding request, bit k for instance k
  logic [1:0] oq [$];
  int         last_rr = 1;
  logic       err_m   = 1'b0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    scr1_memif_arb #(
      .ORDER_DEPTH(DEPTH),
      .ADDR_WIDTH (32),
      .FIXED_PRIO (k)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m0_req    (m0_req),
      .m0_req_ack(ack0[k]),
      .m0_cmd    (m0_cmd),
      .m0_width  (m0_width),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_rdata  (rdata0[k]),
      .m0_resp   (resp0[k]),
      .m1_req    (m1_req),
      .m1_req_ack(ack1[k]),
      .m1_cmd    (m1_cmd),
      .m1_width  (m1_width),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_rdata  (rdata1[k]),
      .m1_resp   (resp1[k]),
      .s_req     (sreq[k]),
      .s_req_ack (s_req_ack),
      .s_cmd     (scmd[k]),
      .s_width   (swidth[k]),
      .s_addr    (saddr[k]),
      .s_wdata   (swdata[k]),
      .s_rdata   (s_rdata),
      .s_resp    (s_resp),
      .idle      (idle[k]),
      .err_unexp (err[k])
    );
  end

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %h, expected %h", nm, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int         g [2];
    logic       any_m, full_m, pop_m;
    logic [1:0] own;
    logic [63:0] e_cmd, e_w, e_a, e_d;
    if (!rst_n) begin
      oq.delete();
      last_rr = 1;
      err_m   = 1'b0;
    end
    any_m  = m0_req | m1_req;
    full_m = (oq.size() == DEPTH);
    pop_m  = (s_resp != 2'b00) && (oq.size() > 0);
    own    = pop_m ? oq[0] : 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (m0_req && m1_req) g[k] = (k == 1) ? 0 : 1 - last_rr;
      else if (m0_req)      g[k] = 0;
      else if (m1_req)      g[k] = 1;
      else                  g[k] = -1;
      e_cmd = (g[k] == 0) ? 64'(m0_cmd)   : (g[k] == 1) ? 64'(m1_cmd)   : 64'd0;
      e_w   = (g[k] == 0) ? 64'(m0_width) : (g[k] == 1) ? 64'(m1_width) : 64'd0;
      e_a   = (g[k] == 0) ? 64'(m0_addr)  : (g[k] == 1) ? 64'(m1_addr)  : 64'd0;
      e_d   = (g[k] == 0) ? 64'(m0_wdata) : (g[k] == 1) ? 64'(m1_wdata) : 64'd0;
      chk("s_req",   k, 64'(sreq[k]),   64'(any_m && !full_m));
      chk("s_cmd",   k, 64'(scmd[k]),   e_cmd);
      chk("s_width", k, 64'(swidth[k]), e_w);
      chk("s_addr",  k, 64'(saddr[k]),  e_a);
      chk("s_wdata", k, 64'(swdata[k]), e_d);
      chk("m0_ack",  k, 64'(ack0[k]),   64'(g[k] == 0 && s_req_ack && !full_m));
      chk("m1_ack",  k, 64'(ack1[k]),   64'(g[k] == 1 && s_req_ack && !full_m));
      chk("m0_resp", k, 64'(resp0[k]),  (pop_m && !own[k]) ? 64'(s_resp)  : 64'd0);
      chk("m0_rdata",k, 64'(rdata0[k]), (pop_m && !own[k]) ? 64'(s_rdata) : 64'd0);
      chk("m1_resp", k, 64'(resp1[k]),  (pop_m &&  own[k]) ? 64'(s_resp)  : 64'd0);
      chk("m1_rdata",k, 64'(rdata1[k]), (pop_m &&  own[k]) ? 64'(s_rdata) : 64'd0);
      chk("idle",    k, 64'(idle[k]),   64'(oq.size() == 0));
      chk("err",     k, 64'(err[k]),    64'(err_m));
    end
    if (rst_n) begin
      if (s_resp != 2'b00) begin
        if (oq.size() > 0) void'(oq.pop_front());
        else               err_m = 1'b1;
      end
      if (any_m && !full_m && s_req_ack) begin
        oq.push_back({g[1] == 1, g[0] == 1});
        last_rr = g[0];
      end
    end
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req = 0; m0_cmd = 0; m0_width = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_cmd = 0; m1_width = 0; m1_addr = 0; m1_wdata = 0;
    s_req_ack = 0; s_resp = 0; s_rdata = 0;
    nxt; nxt;
    #1 chk("rst_idle", 0, 64'(idle[0]), 64'd1);
    chk("rst_sreq", 0, 64'(sreq[0]), 64'd0);
    nxt; rst_n = 1'b1;

    // single read from port 0
    nxt; m0_req = 1; m0_width = 2; m0_addr = 32'h100; s_req_ack = 1;
    #2 chk("sr_ack0", 0, 64'(ack0[0]), 64'd1);
    chk("sr_addr", 0, 64'(saddr[0]), 64'h100);
    nxt; m0_req = 0; m0_addr = 0; m0_width = 0; s_req_ack = 0;
    nxt;
    nxt; s_resp = 1; s_rdata = 32'hDEADBEEF;
    #2 chk("sr_resp0", 0, 64'(resp0[0]), 64'd1);
    chk("sr_rdata0", 0, 64'(rdata0[0]), 64'hDEADBEEF);
    chk("sr_resp1", 0, 64'(resp1[0]), 64'd0);
    nxt; s_resp = 0; s_rdata = 0;
    #2 chk("sr_idle", 0, 64'(idle[0]), 64'd1);

    // port 1 write completing with error
    nxt; m1_req = 1; m1_cmd = 1; m1_width = 1; m1_addr = 32'h200; m1_wdata = 32'h12345678; s_req_ack = 1;
    #2 chk("wr_wdata", 0, 64'(swdata[0]), 64'h12345678);
    chk("wr_ack1", 0, 64'(ack1[0]), 64'd1);
    nxt; m1_req = 0; m1_cmd = 0; m1_width = 0; m1_addr = 0; m1_wdata = 0; s_req_ack = 0;
    s_resp = 2; s_rdata = 32'hBAD0BAD0;
    #2 chk("wr_resp1", 0, 64'(resp1[0]), 64'd2);
    chk("wr_resp0", 0, 64'(resp0[0]), 64'd0);
    nxt; s_resp = 0; s_rdata = 0;

    // contention: both held, responses every cycle
    nxt; m0_req = 1; m1_req = 1; m0_addr = 32'h1000; m1_addr = 32'h2000; s_req_ack = 1;
    #2 chk("rr_c1_ack0", 0, 64'(ack0[0]), 64'd1);
    chk("rr_c1_ack1", 0, 64'(ack1[0]), 64'd0);
    chk("fp_c1_ack0", 1, 64'(ack0[1]), 64'd1);
    nxt; s_resp = 1; s_rdata = 32'hA0;
    #2 chk("rr_c2_ack1", 0, 64'(ack1[0]), 64'd1);
    chk("rr_c2_resp0", 0, 64'(resp0[0]), 64'd1);
    chk("fp_c2_ack1", 1, 64'(ack1[1]), 64'd0);
    for (int i = 0; i < 5; i++) begin
      nxt; s_rdata = 32'hA1 + 32'(i);
    end
    nxt; m0_req = 0; m1_req = 0; m0_addr = 0; m1_addr = 0; s_req_ack = 0; s_rdata = 32'hB0;
    nxt; s_resp = 0; s_rdata = 0;
    #2 chk("rr_idle", 0, 64'(idle[0]), 64'd1);

    // fill the tag FIFO
    nxt; m0_req = 1; m0_addr = 32'h300; s_req_ack = 1;
    nxt;
    #2 chk("full_sreq_pre", 0, 64'(sreq[0]), 64'd1);
    nxt;
    #2 chk("full_sreq", 0, 64'(sreq[0]), 64'd0);
    chk("full_ack0", 0, 64'(ack0[0]), 64'd0);
    chk("full_ack0", 1, 64'(ack0[1]), 64'd0);
    nxt; s_resp = 1; s_rdata = 32'h11;
    #2 chk("full_pop_sreq", 0, 64'(sreq[0]), 64'd0);
    chk("full_pop_resp0", 0, 64'(resp0[0]), 64'd1);
    nxt; s_resp = 0; s_rdata = 0;
    #2 chk("full_reopen", 0, 64'(sreq[0]), 64'd1);
    nxt; s_req_ack = 0;
    #2 chk("full_again", 0, 64'(sreq[0]), 64'd0);
    nxt; m0_req = 0; m0_addr = 0; s_resp = 1; s_rdata = 32'h22;
    nxt; s_rdata = 32'h33;
    nxt; s_resp = 0; s_rdata = 0;
    #2 chk("drain_idle", 0, 64'(idle[0]), 64'd1);

    // unexpected response
    nxt; s_resp = 1; s_rdata = 32'h44;
    #2 chk("unexp_resp0", 0, 64'(resp0[0]), 64'd0);
    chk("unexp_resp1", 0, 64'(resp1[0]), 64'd0);
    nxt; s_resp = 0; s_rdata = 0;
    #2 chk("unexp_err", 0, 64'(err[0]), 64'd1);
    chk("unexp_err", 1, 64'(err[1]), 64'd1);

    // reset with two outstanding
    nxt; m0_req = 1; m1_req = 1; s_req_ack = 1;
    nxt;
    nxt; m0_req = 0; m1_req = 0; s_req_ack = 0;
    #2 chk("pre_rst_idle", 0, 64'(idle[0]), 64'd0);
    rst_n = 1'b0;
    #1 chk("arst_idle", 0, 64'(idle[0]), 64'd1);
    chk("arst_sreq", 0, 64'(sreq[0]), 64'd0);
    chk("arst_err", 0, 64'(err[0]), 64'd0);
    chk("arst_idle", 1, 64'(idle[1]), 64'd1);
    nxt; rst_n = 1'b1;
    nxt; m0_req = 1; m1_req = 1; s_req_ack = 1;
    #2 chk("post_rst_ack0", 0, 64'(ack0[0]), 64'd1);
    chk("post_rst_ack1", 0, 64'(ack1[0]), 64'd0);
    nxt; m0_req = 0; m1_req = 0; s_req_ack = 0; s_resp = 1; s_rdata = 32'h55;
    #2 chk("post_rst_resp0", 0, 64'(resp0[0]), 64'd1);
    nxt; s_resp = 0; s_rdata = 0;
    nxt;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
